// File: rtl/wb_g18_prog.sv
// Wishbone program/erase controller for the G18 parallel NOR flash.
// Register writes launch command-bus sequences (program, erase, unlock, clear status);
// program and erase poll the flash status register, and every sequence ends in read-array mode.
module wb_g18_prog #(
  parameter int unsigned G18Aw     = 25,
  parameter int unsigned WbDw      = 32,
  parameter int unsigned WbAw      = 32,
  parameter int unsigned TSetup    = 2,
  parameter int unsigned TPulse    = 4,
  parameter int unsigned THold     = 2,
  parameter int unsigned RdLatency = 15,
  parameter int unsigned PollLimit = 1048576
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WbAw-1:0]  wb_adr_i,
  input  logic [WbDw-1:0]  wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic [1:0]       wb_bte_i,
  input  logic [2:0]       wb_cti_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic [WbDw-1:0]  wb_dat_o,
  input  logic [15:0]      g18_dat_i,
  output logic [15:0]      g18_dat_o,
  output logic             g18_dat_oe_o,
  output logic [G18Aw-1:0] g18_adr_o,
  output logic             g18_csn_o,
  output logic             g18_oen_o,
  output logic             g18_wen_o,
  output logic             g18_advn_o,
  output logic             g18_clk_o,
  output logic             g18_rstn_o,
  output logic             busy_o
);

  localparam int unsigned TMaxA = (TSetup > TPulse) ? TSetup : TPulse;
  localparam int unsigned TMaxB = (THold > RdLatency) ? THold : RdLatency;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned CntW  = $clog2(TMax) + 1;
  localparam int unsigned PollW = $clog2(PollLimit) + 1;

  localparam logic [2:0] CmdProg   = 3'd1;
  localparam logic [2:0] CmdErase  = 3'd2;
  localparam logic [2:0] CmdUnlock = 3'd3;
  localparam logic [2:0] CmdClear  = 3'd4;

  typedef enum logic [3:0] {
    StIdle, StWrSetup, StWrPulse, StWrHold, StWrGap, StRdWait, StRdGap, StNext, StDone
  } state_e;

  typedef enum logic [1:0] {OpWrite, OpPoll, OpEnd} op_e;

  // Kind of bus operation at a given step of a command sequence.
  function automatic op_e step_kind(input logic [2:0] cmd, input logic [2:0] step);
    op_e k;
    k = OpEnd;
    case (cmd)
      CmdProg, CmdErase: k = (step == 3'd2) ? OpPoll : ((step <= 3'd3) ? OpWrite : OpEnd);
      CmdUnlock:         k = (step <= 3'd2) ? OpWrite : OpEnd;
      CmdClear:          k = (step <= 3'd1) ? OpWrite : OpEnd;
      default:           k = OpEnd;
    endcase
    return k;
  endfunction

  // Command word for a write step; anything not listed is the closing read-array word.
  function automatic logic [15:0] step_word(input logic [2:0] cmd, input logic [2:0] step,
                                            input logic [15:0] data);
    logic [15:0] w;
    w = 16'h00FF;
    case (cmd)
      CmdProg:   if (step == 3'd0) w = 16'h0041; else if (step == 3'd1) w = data;
      CmdErase:  if (step == 3'd0) w = 16'h0020; else if (step == 3'd1) w = 16'h00D0;
      CmdUnlock: if (step == 3'd0) w = 16'h0060; else if (step == 3'd1) w = 16'h00D0;
      CmdClear:  if (step == 3'd0) w = 16'h0050;
      default:   w = 16'h00FF;
    endcase
    return w;
  endfunction

  state_e             state_q;
  logic [2:0]         cmd_q, step_q;
  logic [CntW-1:0]    cnt_q;
  logic [PollW-1:0]   poll_cnt_q, poll_inc;
  logic               poll_done_q, poll_hit_limit;
  logic               busy_q, error_q, timeout_q;
  logic [7:0]         sr_q;
  logic               csn_q, oen_q, wen_q, advn_q, dat_oe_q;
  logic [G18Aw-1:0]   adr_q, addr_q;
  logic [15:0]        fdat_q, data_q;
  logic               ack_q;
  logic [WbDw-1:0]    dat_o_q, rd_data, status_w;
  logic               req, cmd_valid, cmd_accept;
  logic [1:0]         reg_sel;
  op_e                nxt_kind;
  logic [15:0]        nxt_word;

  assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign reg_sel    = wb_adr_i[3:2];
  assign cmd_valid  = (wb_dat_i[WbDw-1:3] == '0) && (wb_dat_i[2:0] != 3'd0) &&
                      (wb_dat_i[2:0] <= CmdClear);
  assign cmd_accept = req & wb_we_i & (reg_sel == 2'd2) & ~busy_q & cmd_valid;

  assign nxt_kind = step_kind(cmd_q, step_q);
  assign nxt_word = step_word(cmd_q, step_q, data_q);

  assign poll_inc       = poll_cnt_q + PollW'(1);
  assign poll_hit_limit = (poll_inc == PollW'(PollLimit));

  assign status_w = {{(WbDw-16){1'b0}}, sr_q, 5'b0, timeout_q, error_q, busy_q};

  // Register read mux; CMD is write-only and reads back as zero.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0:    rd_data[G18Aw-1:0] = addr_q;
      2'd1:    rd_data[15:0] = data_q;
      2'd3:    rd_data = status_w;
      default: rd_data = '0;
    endcase
  end

  // Wishbone slave: single-cycle ack, read data registered with ack, ADDR/DATA locked while busy.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      ack_q <= req;
      if (req && wb_we_i && !busy_q) begin
        case (reg_sel)
          2'd0:    addr_q <= wb_dat_i[G18Aw-1:0];
          2'd1:    data_q <= wb_dat_i[15:0];
          default: ;
        endcase
      end
      if (req && !wb_we_i) dat_o_q <= rd_data;
    end
  end

  // Sequencer: steps through command words, times each bus cycle, polls SR, drives the pins.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      poll_cnt_q  <= '0;
      poll_done_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      sr_q        <= '0;
      csn_q       <= 1'b1;
      oen_q       <= 1'b1;
      wen_q       <= 1'b1;
      advn_q      <= 1'b1;
      dat_oe_q    <= 1'b0;
      adr_q       <= '0;
      fdat_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_accept) begin
            cmd_q     <= wb_dat_i[2:0];
            step_q    <= '0;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= StNext;
          end
        end
        StWrSetup: begin
          if (cnt_q == '0) begin
            wen_q   <= 1'b0;
            cnt_q   <= CntW'(TPulse - 1);
            state_q <= StWrPulse;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StWrPulse: begin
          if (cnt_q == '0) begin
            wen_q   <= 1'b1;
            cnt_q   <= CntW'(THold - 1);
            state_q <= StWrHold;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StWrHold: begin
          if (cnt_q == '0) begin
            csn_q    <= 1'b1;
            advn_q   <= 1'b1;
            dat_oe_q <= 1'b0;
            step_q   <= step_q + 3'd1;
            state_q  <= StWrGap;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StRdWait: begin
          if (cnt_q == '0) begin
            csn_q      <= 1'b1;
            advn_q     <= 1'b1;
            oen_q      <= 1'b1;
            sr_q       <= g18_dat_i[7:0];
            poll_cnt_q <= poll_inc;
            state_q    <= StRdGap;
            if (g18_dat_i[7]) begin
              error_q     <= |g18_dat_i[5:1];
              poll_done_q <= 1'b1;
              step_q      <= step_q + 3'd1;
            end else if (poll_hit_limit) begin
              error_q     <= 1'b1;
              timeout_q   <= 1'b1;
              poll_done_q <= 1'b1;
              step_q      <= step_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        // Gap states double as the launch point so only one idle cycle separates bus cycles.
        StNext, StWrGap, StRdGap: begin
          if (state_q == StRdGap && !poll_done_q) begin
            csn_q   <= 1'b0;
            advn_q  <= 1'b0;
            oen_q   <= 1'b0;
            cnt_q   <= CntW'(RdLatency - 1);
            state_q <= StRdWait;
          end else begin
            unique case (nxt_kind)
              OpWrite: begin
                csn_q    <= 1'b0;
                advn_q   <= 1'b0;
                dat_oe_q <= 1'b1;
                adr_q    <= addr_q;
                fdat_q   <= nxt_word;
                cnt_q    <= CntW'(TSetup - 1);
                state_q  <= StWrSetup;
              end
              OpPoll: begin
                csn_q       <= 1'b0;
                advn_q      <= 1'b0;
                oen_q       <= 1'b0;
                adr_q       <= addr_q;
                cnt_q       <= CntW'(RdLatency - 1);
                poll_cnt_q  <= '0;
                poll_done_q <= 1'b0;
                state_q     <= StRdWait;
              end
              default: state_q <= StDone;
            endcase
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_in;
  assign unused_in = ^{wb_sel_i, wb_bte_i, wb_cti_i, wb_adr_i[WbAw-1:4], wb_adr_i[1:0],
                       wb_dat_i[WbDw-1:G18Aw], g18_dat_i[15:8], g18_dat_i[6]};

  assign wb_ack_o     = ack_q;
  assign wb_err_o     = 1'b0;
  assign wb_dat_o     = dat_o_q;
  assign g18_dat_o    = fdat_q;
  assign g18_dat_oe_o = dat_oe_q;
  assign g18_adr_o    = adr_q;
  assign g18_csn_o    = csn_q;
  assign g18_oen_o    = oen_q;
  assign g18_wen_o    = wen_q;
  assign g18_advn_o   = advn_q;
  assign g18_clk_o    = 1'b0;
  assign g18_rstn_o   = ~wb_rst_i;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_wb_g18_prog.sv
// Bench for wb_g18_prog: directed and random commands against a sequence-level flash model.
module tb_wb_g18_prog;

  localparam int unsigned PollLim = 8;
  localparam int unsigned TPulse  = 4;
  localparam int unsigned RdLat   = 15;
  localparam logic [31:0] RegAddr = 32'h0;
  localparam logic [31:0] RegData = 32'h4;
  localparam logic [31:0] RegCmd  = 32'h8;
  localparam logic [31:0] RegStat = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_adr, wb_dat;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic [15:0] g18_dat_i, g18_dat_o;
  logic        g18_dat_oe_o, g18_csn_o, g18_oen_o, g18_wen_o, g18_advn_o, g18_clk_o;
  logic        g18_rstn_o, busy_o;
  logic [24:0] g18_adr_o;

  int checks = 0;
  int failures = 0;

  // Flash model: SR reads return sr_busy until the ready_at-th read, then sr_final.
  int          oe_falls = 0;
  int          ready_at = 1;
  logic [7:0]  sr_final = 8'h80;
  logic [7:0]  sr_busy  = 8'h00;
  always_comb g18_dat_i = {8'hC3, (oe_falls >= ready_at) ? sr_final : sr_busy};

  // Model of architecturally visible status.
  logic [7:0] m_sr = 8'h00;
  logic       m_err = 1'b0, m_to = 1'b0;

  logic [15:0] got_dat[$];
  logic [24:0] got_adr[$];
  int          rd_count = 0;

  always #5 clk = ~clk;

  wb_g18_prog #(.PollLimit(PollLim)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat),
    .wb_sel_i    (4'hF),
    .wb_we_i     (wb_we),
    .wb_bte_i    (2'b00),
    .wb_cti_i    (3'b000),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .wb_dat_o    (wb_dat_o),
    .g18_dat_i   (g18_dat_i),
    .g18_dat_o   (g18_dat_o),
    .g18_dat_oe_o(g18_dat_oe_o),
    .g18_adr_o   (g18_adr_o),
    .g18_csn_o   (g18_csn_o),
    .g18_oen_o   (g18_oen_o),
    .g18_wen_o   (g18_wen_o),
    .g18_advn_o  (g18_advn_o),
    .g18_clk_o   (g18_clk_o),
    .g18_rstn_o  (g18_rstn_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: pin invariants, bus-cycle timing, and capture of every flash write.
  logic prev_wen = 1'b1, prev_oen = 1'b1, prev_ack = 1'b0;
  int   wen_low = 0, oe_low = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_wen = 1'b1; prev_oen = 1'b1; prev_ack = 1'b0; wen_low = 0; oe_low = 0;
      chk("rst_pins", {g18_csn_o, g18_oen_o, g18_wen_o, g18_advn_o, g18_dat_oe_o, busy_o,
                       g18_rstn_o, wb_ack_o}, 8'b1111_0000);
    end else begin
      chk("static_outs", {wb_err_o, g18_clk_o, g18_rstn_o}, 3'b001);
      if (!busy_o)
        chk("idle_bus", {g18_csn_o, g18_oen_o, g18_wen_o, g18_advn_o, g18_dat_oe_o}, 5'b11110);
      chk("oe_vs_drive", {1'b0, !g18_oen_o && g18_dat_oe_o}, 0);
      chk("ack_b2b", {1'b0, prev_ack && wb_ack_o}, 0);
      if (!g18_wen_o || !g18_oen_o) chk("csn_with_strobe", {g18_csn_o, g18_advn_o}, 2'b00);
      if (!g18_wen_o) begin
        wen_low++;
        chk("drive_in_pulse", g18_dat_oe_o, 1);
      end else if (!prev_wen) begin
        chk("we_pulse_len", wen_low, TPulse);
        got_dat.push_back(g18_dat_o);
        got_adr.push_back(g18_adr_o);
        wen_low = 0;
      end
      if (!g18_oen_o) begin
        oe_low++;
        if (prev_oen) oe_falls++;
      end else if (!prev_oen) begin
        chk("oe_pulse_len", oe_low, RdLat);
        rd_count++;
        oe_low = 0;
      end
      prev_wen = g18_wen_o; prev_oen = g18_oen_o; prev_ack = wb_ack_o;
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = wdat;
    @(negedge clk);
    n = 1;
    while (!wb_ack_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ack_latency", n, 1);
    rdat = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_bound", busy_o, 0);
  endtask

  // One command end to end; the expected write list and read count come from the command table.
  task automatic run_cmd(input logic [2:0] code, input logic [24:0] a, input logic [15:0] d,
                         input int rdy, input logic [7:0] srf, input logic [7:0] srb,
                         input bit meddle, output logic [31:0] stat);
    logic [15:0] exp_w[$];
    logic [31:0] r;
    int          exp_reads;
    bit          valid, polls;
    got_dat.delete(); got_adr.delete(); rd_count = 0; oe_falls = 0;
    ready_at = rdy; sr_final = srf; sr_busy = srb;
    valid = (code >= 3'd1 && code <= 3'd4);
    polls = (code == 3'd1 || code == 3'd2);
    case (code)
      3'd1: exp_w = '{16'h0041, d, 16'h00FF};
      3'd2: exp_w = '{16'h0020, 16'h00D0, 16'h00FF};
      3'd3: exp_w = '{16'h0060, 16'h00D0, 16'h00FF};
      3'd4: exp_w = '{16'h0050, 16'h00FF};
      default: exp_w = '{};
    endcase
    exp_reads = polls ? ((rdy <= int'(PollLim)) ? rdy : int'(PollLim)) : 0;
    if (valid) begin
      m_err = 1'b0; m_to = 1'b0;
      if (polls) begin
        if (rdy <= int'(PollLim)) begin
          m_sr = srf; m_err = |srf[5:1];
        end else begin
          m_sr = srb; m_err = 1'b1; m_to = 1'b1;
        end
      end
    end
    wb_write(RegAddr, {7'b0, a});
    wb_write(RegData, {16'b0, d});
    wb_write(RegCmd, {29'b0, code});
    chk("busy_after_cmd", busy_o, valid);
    if (meddle && valid) begin
      wb_write(RegAddr, 32'h1);
      wb_write(RegCmd, 32'h4);
    end
    wait_not_busy();
    chk("n_writes", got_dat.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_dat.size(); i++) begin
      chk("write_word", got_dat[i], exp_w[i]);
      chk("write_adr", got_adr[i], a);
    end
    chk("n_reads", rd_count, exp_reads);
    wb_read(RegStat, stat);
    chk("status", stat, {16'h0, m_sr, 5'b0, m_to, m_err, 1'b0});
    wb_read(RegAddr, r);
    chk("addr_rb", r, {7'b0, a});
    wb_read(RegData, r);
    chk("data_rb", r, {16'b0, d});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st, r;
    logic [2:0]  code;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_adr_dat", {g18_adr_o, g18_dat_o}, 0);
    rst = 1'b0;
    wb_read(RegStat, r);
    chk("rst_status", r, 32'h0);
    wb_read(RegAddr, r);
    chk("rst_addr", r, 32'h0);

    // Program: SR ready on the 3rd read.
    run_cmd(3'd1, 25'h12345, 16'hBEEF, 3, 8'h80, 8'h00, 1'b0, st);
    chk("prog_status_lit", st, 32'h0000_8000);
    chk("prog_word1_lit", (got_dat.size() > 1) ? got_dat[1] : 16'hxxxx, 16'hBEEF);
    chk("prog_reads_lit", rd_count, 3);
    wb_read(RegCmd, r);
    chk("cmd_reads_zero", r, 32'h0);

    // Erase with a failing SR.
    run_cmd(3'd2, 25'h1F0000, 16'h0000, 1, 8'hA0, 8'h00, 1'b0, st);
    chk("erase_status_lit", st, 32'h0000_A002);

    // Timeout: SR never becomes ready.
    run_cmd(3'd2, 25'h0000AA, 16'h0000, 1000, 8'h80, 8'h00, 1'b0, st);
    chk("timeout_status_lit", st, 32'h0000_0006);
    chk("timeout_reads_lit", rd_count, 8);
    chk("timeout_last_ff", (got_dat.size() == 3) ? got_dat[2] : 16'hxxxx, 16'h00FF);

    // Writes while busy are acked and dropped.
    run_cmd(3'd1, 25'h12345, 16'h5A5A, 4, 8'h80, 8'h00, 1'b1, st);

    // Unlock then clear: no status reads at all.
    run_cmd(3'd3, 25'h0ABCDE, 16'h0000, 1, 8'h80, 8'h00, 1'b0, st);
    chk("unlock_w0_lit", (got_dat.size() > 0) ? got_dat[0] : 16'hxxxx, 16'h0060);
    run_cmd(3'd4, 25'h0ABCDE, 16'h0000, 1, 8'h80, 8'h00, 1'b0, st);
    chk("clear_w0_lit", (got_dat.size() > 0) ? got_dat[0] : 16'hxxxx, 16'h0050);

    // Random mix, including ignored codes and busy-time interference.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 3);
        code = (r[1:0] == 2'd0) ? 3'd0 : (3'd4 + 3'(r[1:0]));
      end else begin
        code = 3'($urandom_range(1, 4));
      end
      run_cmd(code, 25'($urandom), 16'($urandom), $urandom_range(1, 10),
              {1'b1, 7'($urandom)}, {1'b0, 7'($urandom)}, 1'($urandom), st);
    end

    // Asynchronous reset in the middle of a program WE# pulse.
    ready_at = 1000;
    wb_write(RegAddr, 32'h0ABCD);
    wb_write(RegData, 32'h1234);
    wb_write(RegCmd, 32'h1);
    begin
      int n = 0;
      while (g18_wen_o && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("reached_pulse", g18_wen_o, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst", {g18_csn_o, g18_oen_o, g18_wen_o, g18_advn_o, g18_dat_oe_o, busy_o},
        6'b111100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_sr = 8'h00; m_err = 1'b0; m_to = 1'b0;
    wb_read(RegStat, r);
    chk("post_rst_status", r, 32'h0);
    wb_read(RegAddr, r);
    chk("post_rst_addr", r, 32'h0);

    // Recovery after reset.
    run_cmd(3'd1, 25'h00777, 16'hC0DE, 2, 8'h90, 8'h00, 1'b0, st);
    chk("recover_status_lit", st, 32'h0000_9002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
